// File: rtl/led_panel_pkg.sv
// Shared constants and helpers for the HUB75 scan controller (led_scan_ctrl).
package led_panel_pkg;

  localparam logic [1:0] StShift   = 2'd0;
  localparam logic [1:0] StLatch   = 2'd1;
  localparam logic [1:0] StDisplay = 2'd2;

  localparam int unsigned ROW_W   = 4;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned BUF_BIT = 9;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  // Returns {R[plane], G[plane], B[plane]} of a packed 24-bit pixel.
  function automatic logic [2:0] plane_bits(input logic [23:0] pix, input logic [7:0] plane);
    logic [CH_W-1:0] r, g, b;
    r = pix[R_LSB +: CH_W] >> plane;
    g = pix[G_LSB +: CH_W] >> plane;
    b = pix[B_LSB +: CH_W] >> plane;
    return {r[0], g[0], b[0]};
  endfunction

endpackage

// File: rtl/led_shift_unit.sv
// SHIFT-phase sequencer: issues one column read every two cycles, tracks the
// memory latency, and drives the panel colour bits and shift clock.
module led_shift_unit
  import led_panel_pkg::*;
#(
  parameter int unsigned PLANE_W = 3,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic [PLANE_W-1:0] plane,
  input  logic [23:0]        rd_data_hi,
  input  logic [23:0]        rd_data_lo,
  output logic [COL_W-1:0]   col,
  output logic               first,
  output logic               done,
  output logic               panel_r1,
  output logic               panel_g1,
  output logic               panel_b1,
  output logic               panel_r2,
  output logic               panel_g2,
  output logic               panel_b2,
  output logic               panel_clk
);

  localparam int unsigned NumCols  = 1 << COL_W;
  localparam int unsigned ShiftLen = 2 * NumCols + RD_LAT;
  localparam int unsigned CntW     = $clog2(ShiftLen);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [2:0]        hi_q, hi_d, lo_q, lo_d;
  logic              pend_q, pend_d, clk_q, clk_d;
  logic              issue, data_vld;

  assign col      = cnt_q[COL_W:1];
  assign first    = active && (cnt_q == '0);
  assign done     = active && (cnt_q == CntW'(ShiftLen - 1));
  assign issue    = active && !cnt_q[0] && (cnt_q < CntW'(2 * NumCols));
  assign vld_d    = RD_LAT'({vld_q, issue});
  assign data_vld = vld_q[RD_LAT-1];

  always_comb begin
    cnt_d  = '0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = 1'b0;
    clk_d  = 1'b0;
    if (active) cnt_d = done ? '0 : cnt_q + 1'b1;
    // Data is presented with the clock low, then the clock rises a cycle later.
    if (data_vld) begin
      hi_d   = plane_bits(rd_data_hi, 8'(plane));
      lo_d   = plane_bits(rd_data_lo, 8'(plane));
      pend_d = 1'b1;
    end else if (pend_q) begin
      clk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      vld_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
    end
  end

  assign {panel_r1, panel_g1, panel_b1} = hi_q;
  assign {panel_r2, panel_g2, panel_b2} = lo_q;
  assign panel_clk = clk_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 32x32 1:16 scan controller with BCM planes and buffer-swap handshake.
// Optional per-frame brightness scaling of DISPLAY when LED_BRIGHTNESS_EN is defined.
module led_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BASE_TICKS = 4,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  rd_addr,
  input  logic [23:0] rd_data_hi,
  input  logic [23:0] rd_data_lo,
  output logic        actual_buffer,
  input  logic        swap_req,
`ifdef LED_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic        swap_ack,
  output logic        frame_start,
  output logic        panel_r1,
  output logic        panel_g1,
  output logic        panel_b1,
  output logic        panel_r2,
  output logic        panel_g2,
  output logic        panel_b2,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic [3:0]  panel_row
);

  localparam int unsigned PlaneW   = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int unsigned MaxTicks = BASE_TICKS << (PWM_BITS - 1);
  localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, prow_q, prow_d;
  logic [PlaneW-1:0] plane_q, plane_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             display_buf_q, display_buf_d, armed_q, armed_d;
  logic [COL_W-1:0] col;
  logic             shift_first, shift_done, disp_last, frame_end, oe_en;
  logic [31:0]      disp_len;

  led_shift_unit #(
    .PLANE_W (PlaneW),
    .RD_LAT  (RD_LAT)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state_q == StShift),
    .plane      (plane_q),
    .rd_data_hi (rd_data_hi),
    .rd_data_lo (rd_data_lo),
    .col        (col),
    .first      (shift_first),
    .done       (shift_done),
    .panel_r1   (panel_r1),
    .panel_g1   (panel_g1),
    .panel_b1   (panel_b1),
    .panel_r2   (panel_r2),
    .panel_g2   (panel_g2),
    .panel_b2   (panel_b2),
    .panel_clk  (panel_clk)
  );

  assign disp_len  = BASE_TICKS << plane_q;
  assign disp_last = (32'(tick_q) == disp_len - 32'd1);
  assign frame_end = (state_q == StDisplay) && disp_last
                     && (plane_q == PlaneW'(PWM_BITS - 1)) && (&row_q);

`ifdef LED_BRIGHTNESS_EN
  logic [7:0] bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bright_q <= 8'hff;
    else if (frame_start) bright_q <= brightness;
  end

  assign oe_en = (32'(tick_q) << 8) < disp_len * (32'(bright_q) + 32'd1);
`else
  assign oe_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    prow_d  = prow_q;
    plane_d = plane_q;
    tick_d  = tick_q;
    case (state_q)
      StShift: begin
        if (shift_done) begin
          state_d = StLatch;
          prow_d  = row_q;
        end
      end
      StLatch: begin
        state_d = StDisplay;
        tick_d  = '0;
      end
      StDisplay: begin
        tick_d = tick_q + 1'b1;
        if (disp_last) begin
          state_d = StShift;
          tick_d  = '0;
          if (plane_q == PlaneW'(PWM_BITS - 1)) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = StShift;
    endcase
  end

  // A request only counts once it has been seen low since the last ack.
  assign swap_ack      = frame_end && swap_req && armed_q;
  assign display_buf_d = display_buf_q ^ swap_ack;
  assign armed_d       = swap_ack ? 1'b0 : (!swap_req ? 1'b1 : armed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StShift;
      row_q         <= '0;
      prow_q        <= '0;
      plane_q       <= '0;
      tick_q        <= '0;
      display_buf_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      prow_q        <= prow_d;
      plane_q       <= plane_d;
      tick_q        <= tick_d;
      display_buf_q <= display_buf_d;
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    rd_addr                = '0;
    rd_addr[BUF_BIT]       = display_buf_q;
    rd_addr[COL_W +: ROW_W] = row_q;
    rd_addr[0 +: COL_W]    = col;
  end

  assign actual_buffer = ~display_buf_d;
  // Gated by rst_n so the pulse is absent while held in reset.
  assign frame_start   = rst_n && shift_first && (row_q == '0) && (plane_q == '0);
  assign panel_oe_n    = !((state_q == StDisplay) && oe_en);
  assign panel_lat     = (state_q == StLatch) || (state_q == StDisplay);
  assign panel_row     = prow_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl (default parameters).
module tb_led_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data_hi = '0, rd_data_lo = '0, hi_p1 = '0, lo_p1 = '0;
  logic        actual_buffer, swap_req = 1'b0, swap_ack, frame_start;
  logic        panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
  logic        panel_clk, panel_lat, panel_oe_n;
  logic [3:0]  panel_row;
  logic [7:0]  brightness = 8'hff;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  led_scan_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .rd_data_hi    (rd_data_hi),
    .rd_data_lo    (rd_data_lo),
    .actual_buffer (actual_buffer),
    .swap_req      (swap_req),
`ifdef LED_BRIGHTNESS_EN
    .brightness    (brightness),
`endif
    .swap_ack      (swap_ack),
    .frame_start   (frame_start),
    .panel_r1      (panel_r1),
    .panel_g1      (panel_g1),
    .panel_b1      (panel_b1),
    .panel_r2      (panel_r2),
    .panel_g2      (panel_g2),
    .panel_b2      (panel_b2),
    .panel_clk     (panel_clk),
    .panel_lat     (panel_lat),
    .panel_oe_n    (panel_oe_n),
    .panel_row     (panel_row)
  );

  always #5 clk = ~clk;

  // Two-stage read pipeline: upper half red only at column 0, lower half blue everywhere.
  always @(posedge clk) begin
    hi_p1      <= (rd_addr[4:0] == 5'd0) ? 24'hFF0000 : 24'h000000;
    lo_p1      <= 24'h0000FF;
    rd_data_hi <= hi_p1;
    rd_data_lo <= lo_p1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc = 0;
  endtask

  // Returns the oe_n-low width of the next DISPLAY window.
  task automatic measure_oe(output int width, output logic [3:0] row_seen);
    int n = 0;
    while (panel_oe_n && n < 2000) begin tick(); n++; end
    row_seen = panel_row;
    width = 0;
    while (!panel_oe_n && width < 1000) begin tick(); width++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rd_addr !== 10'h000) begin bad++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr); end
    total++; if ({panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2, panel_clk, panel_lat} !== 8'h00)
      begin bad++; $display("FAIL reset_pins: colour/clk/lat not all 0"); end
    total++; if (panel_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n: got %b want 1", panel_oe_n); end
    total++; if (panel_row !== 4'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", panel_row); end
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL reset_swap_ack: got %b want 0", swap_ack); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    total++; if (actual_buffer !== 1'b1) begin bad++; $display("FAIL reset_actual_buffer: got %b want 1", actual_buffer); end
    rst_n = 1'b1;
    #1;
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL release_frame_start: got %b want 1", frame_start); end
    total++; if (rd_addr !== 10'h000) begin bad++; $display("FAIL release_rd_addr: got %0h want 0", rd_addr); end
    tick();
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL frame_start_pulse: got %b want 0", frame_start); end
    tick();
    total++; if (rd_addr !== 10'h001) begin bad++; $display("FAIL second_read_addr: got %0h want 1", rd_addr); end
  endtask

  task automatic test_shift_data();
    logic prev = 1'b0;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      int rises = 0;
      int n = 0;
      while (rises < 32 && n < 1200) begin
        tick();
        n++;
        if (panel_clk && !prev) begin
          total++; if (panel_r1 !== (rises == 0))
            begin bad++; $display("FAIL shift_r1 p%0d rise%0d: got %b want %b", p, rises, panel_r1, rises == 0); end
          total++; if (panel_b2 !== 1'b1)
            begin bad++; $display("FAIL shift_b2 p%0d rise%0d: got %b want 1", p, rises, panel_b2); end
          total++; if ({panel_g1, panel_b1, panel_r2, panel_g2} !== 4'h0)
            begin bad++; $display("FAIL shift_other p%0d rise%0d: got %0h want 0", p, rises,
                                  {panel_g1, panel_b1, panel_r2, panel_g2}); end
          rises++;
        end
        prev = panel_clk;
      end
      total++; if (rises != 32) begin bad++; $display("FAIL shift_rises p%0d: got %0d want 32", p, rises); end
    end
  endtask

  task automatic test_plane_durations();
    int w;
    logic [3:0] r;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      measure_oe(w, r);
      total++; if (w != (4 << p)) begin bad++; $display("FAIL oe_width p%0d: got %0d want %0d", p, w, 4 << p); end
      total++; if (r !== 4'd0) begin bad++; $display("FAIL oe_row p%0d: got %0d want 0", p, r); end
    end
    while (!frame_start && cyc < 30000) tick();
    total++; if (cyc != 24896) begin bad++; $display("FAIL frame_period: got %0d want 24896", cyc); end
  endtask

  task automatic test_swap();
    cyc = 0;
    total++; if (rd_addr !== 10'h000) begin bad++; $display("FAIL pre_swap_addr: got %0h want 0", rd_addr); end
    repeat (100) tick();
    swap_req = 1'b1;
    while (!swap_ack && cyc < 30000) tick();
    total++; if (cyc != 24895) begin bad++; $display("FAIL swap_ack_cycle: got %0d want 24895", cyc); end
    total++; if (actual_buffer !== 1'b0) begin bad++; $display("FAIL swap_actual_buffer: got %b want 0", actual_buffer); end
    tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL swap_next_frame: got %b want 1", frame_start); end
    total++; if (rd_addr !== 10'h200) begin bad++; $display("FAIL swap_rd_addr: got %0h want 200", rd_addr); end
  endtask

  task automatic test_held_request();
    int acks = 0;
    cyc = 0;
    repeat (24896) begin
      tick();
      if (swap_ack) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL held_swap_acks: got %0d want 0", acks); end
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL held_frame_start: got %b want 1", frame_start); end
    total++; if (rd_addr !== 10'h200) begin bad++; $display("FAIL held_rd_addr: got %0h want 200", rd_addr); end
    total++; if (actual_buffer !== 1'b0) begin bad++; $display("FAIL held_actual_buffer: got %b want 0", actual_buffer); end
    swap_req = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    int w;
    logic [3:0] r;
    cyc = 0;
    repeat (7 * 1556 + 10) tick();
    total++; if (rd_addr !== 10'h2E5) begin bad++; $display("FAIL row7_rd_addr: got %0h want 2e5", rd_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rd_addr !== 10'h000) begin bad++; $display("FAIL async_rd_addr: got %0h want 0", rd_addr); end
    total++; if (actual_buffer !== 1'b1) begin bad++; $display("FAIL async_actual_buffer: got %b want 1", actual_buffer); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc = 0;
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_frame_start: got %b want 1", frame_start); end
    measure_oe(w, r);
    total++; if (w != 4) begin bad++; $display("FAIL restart_oe_width: got %0d want 4", w); end
    total++; if (r !== 4'd0) begin bad++; $display("FAIL restart_row: got %0d want 0", r); end
    while (panel_oe_n && cyc < 500) tick();
    tick();
    tick();
    total++; if (panel_oe_n !== 1'b0) begin bad++; $display("FAIL display_oe_before: got %b want 0", panel_oe_n); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (panel_oe_n !== 1'b1) begin bad++; $display("FAIL async_blank: got %b want 1", panel_oe_n); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef LED_BRIGHTNESS_EN
  task automatic test_brightness();
    int w;
    logic [3:0] r;
    for (int k = 0; k < 2; k++) begin
      brightness = (k == 0) ? 8'd127 : 8'd255;
      do_reset();
      for (int p = 0; p < 8; p++) measure_oe(w, r);
      total++; if (w != ((k == 0) ? 256 : 512))
        begin bad++; $display("FAIL brightness_p7 b%0d: got %0d want %0d", brightness, w, (k == 0) ? 256 : 512); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_shift_data();
    test_plane_durations();
    test_swap();
    test_held_request();
    test_reset_mid_row();
`ifdef LED_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Scan controller for the 32×32 (1:16 scan) HUB75 LED panel. It walks the display half of the double-buffered pixel memory column by column and row by row, through eight binary-coded-modulation (BCM) bit planes. It also drives the panel shift/latch/blank/row pins and owns the buffer-swap handshake that selects which buffer the writer fills via `actual_buffer`. It sits between the pixel memory (read port) and the panel connector.

## Interface
- `PWM_BITS`, 8: bit planes per channel; each channel is 8 bits, and plane `p` uses bit `p` of R, G and B.
- `BASE_TICKS`, 4: display cycles for plane 0; plane `p` displays for `BASE_TICKS << p` cycles.
- `RD_LAT`, 2: memory read latency in clocks, from `rd_addr` to `rd_data_*` valid.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rd_addr` out 10: pixel read address `{display_buf, row[3:0], col[4:0]}`.
- `rd_data_hi` in 24: upper-half pixel, `{R[23:16], G[15:8], B[7:0]}`.
- `rd_data_lo` in 24: lower-half pixel, same layout.
- `actual_buffer` out 1: buffer the writer targets; always `~display_buf`.
- `swap_req` in 1: writer level request; held high until `swap_ack`.
- `swap_ack` out 1: one-cycle pulse; the swap took effect this cycle.
- `frame_start` out 1: one-cycle pulse on the first SHIFT cycle of row 0, plane 0.
- `panel_r1`, `panel_g1`, `panel_b1` out 1 each: upper-half colour bits.
- `panel_r2`, `panel_g2`, `panel_b2` out 1 each: lower-half colour bits.
- `panel_clk` out 1: shift clock; the panel samples on its rising edge.
- `panel_lat` out 1: latch strobe.
- `panel_oe_n` out 1: output enable, active-low.
- `panel_row` out 4: row select A..D.

## Operation
- Scan order: for row 0..15, for plane 0..PWM_BITS-1, run SHIFT → LATCH → DISPLAY. After row 15, plane PWM_BITS-1, the frame ends and the scan wraps to row 0, plane 0.
- SHIFT:
  - One read is issued every 2 cycles, col 0..31.
  - Data returns `RD_LAT` cycles later. The colour bits are then registered (bit `p` of each channel) with `panel_clk`=0, and `panel_clk`=1 on the following cycle.
  - `panel_oe_n`=1 throughout.
- LATCH, 1 cycle:
  - `panel_row` ← current row, `panel_lat`=1, `panel_oe_n`=1.
- DISPLAY:
  - `panel_oe_n`=0 for `BASE_TICKS << p` cycles, then `panel_lat`=0.
  - Advance plane; on plane wrap, advance row.
- Swap:
  - At frame end, if `swap_req`=1 (including assertion in that same cycle): toggle `display_buf`, pulse `swap_ack`. `actual_buffer` changes in the same cycle.
  - A request seen mid-frame waits for frame end.
  - `swap_req` held after ack does not re-swap until it has been low for at least one cycle.
- Reset values:
  - `rd_addr`=0, all colour bits 0, `panel_clk`=0, `panel_lat`=0, `panel_oe_n`=1, `panel_row`=0.
  - `swap_ack`=0, `frame_start`=0, `display_buf`=0, `actual_buffer`=1.
  - FSM returns to SHIFT at row 0, plane 0.
- Reset mid-operation: the panel blanks immediately (asynchronously). The first cycle after release is SHIFT of row 0, plane 0, with `frame_start`=1.

## Timing
- SHIFT takes `2*32 + RD_LAT` cycles (66 at defaults).
- LATCH takes 1 cycle.
- DISPLAY takes `BASE_TICKS << p` cycles.
- Per row, at defaults: 8·67 + 4·255 = 1556 cycles.
- Per frame: 24896 cycles.
- Panel data is stable for the full cycle before each `panel_clk` rising edge.
- `panel_row` never changes while `panel_oe_n`=0.

## Configuration
- `LED_BRIGHTNESS_EN` defined:
  - Adds input `brightness` [7:0], sampled at `frame_start`.
  - In DISPLAY, `panel_oe_n`=0 only while `tick·256 < (BASE_TICKS << p)·(brightness+1)`.
  - DISPLAY length itself is unchanged, so frame timing is identical either way.
- `LED_BRIGHTNESS_EN` undefined: no port; `panel_oe_n`=0 for all of DISPLAY.

## Structure
- Package `led_panel_pkg`:
  - FSM state enum (SHIFT, LATCH, DISPLAY).
  - Address-field localparams: `ROW_W`=4, `COL_W`=5, `BUF_BIT`=9.
  - Pixel channel slice positions.
- Sub-module `led_shift_unit`: read-issue counter, `RD_LAT` valid pipeline, colour-bit selection and `panel_clk` generation. It signals done to the top FSM.

## Test plan
- Reset:
  - Hold `rst_n`=0 → all outputs at their reset values, `actual_buffer`=1.
  - Release → `frame_start` pulses and `rd_addr`=0x000.
- Shift data:
  - Memory returns `rd_data_hi`=0xFF0000 at col 0 and 0 elsewhere, `rd_data_lo`=0x0000FF everywhere.
  - Every plane → `panel_r1`=1 on the first `panel_clk` rise only; `panel_b2`=1 on all 32 rises.
- Plane durations: measure the `panel_oe_n`=0 width for row 0 → 4, 8, 16 … 512 cycles. Frame period = 24896.
- Swap:
  - `swap_req` raised mid-frame → `swap_ack` occurs exactly at frame end; `rd_addr[9]`=1 from the next frame; `actual_buffer`=0.
  - Held request → no second swap.
- Reset mid-SHIFT of row 7 → `panel_oe_n`=1 asynchronously; after release, row 0, plane 0.
- With `LED_BRIGHTNESS_EN`, `brightness`=127 → plane 7 `panel_oe_n`=0 for 256 of 512 cycles; `brightness`=255 → 512.
